// File: rtl/control_sequencer.sv
// control_sequencer
//   Fetch/decode/execute control unit for the alu_system datapath. Fetches a
//   16-bit instruction as two byte reads at PC, decodes BRA/BNE/ADD/LDI/HALT
//   (anything else is a NOP) and steps the datapath through T0..T3.
//   State is the FSM state plus the step counter. Every control output is
//   decoded combinationally from state, step, IR_In, Flags and Reset.
//
// Ports
//   Clock        in   system clock, rising edge
//   Reset        in   synchronous, active-high
//   IR_In[15:0]  in   instruction register contents from the datapath
//   Flags[3:0]   in   {Z,C,N,O}; only Z is used, and only at BNE T2
//   RF_*         out  register-file selects / function / write enables
//   ALU_*        out  ALU function and flag write enable
//   ARF_*        out  address-register-file selects / function / enables
//   IR_LH, IR_Write, Mem_WR, Mem_CS(active-low), DR_E, Mux*Sel, DR_FunSel
//                out  remaining datapath controls
//   Step[2:0]    out  current T-step
//   InstrDone    out  one-cycle pulse on the last step of each instruction
//   Halted       out  high while in HALT
module control_sequencer #(
  parameter logic [4:0] ADD_CODE = 5'b10100,
  parameter logic [5:0] HALT_OP  = 6'h3F
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IR_In,
  input  logic [3:0]  Flags,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [2:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  RF_ScrSel,
  output logic [4:0]  ALU_FunSel,
  output logic        ALU_WF,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [1:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Write,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic        DR_E,
  output logic        MuxDSel,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic [1:0]  MuxCSel,
  output logic [1:0]  DR_FunSel,
  output logic [2:0]  Step,
  output logic        InstrDone,
  output logic        Halted
);

  localparam logic [5:0] OP_BRA = 6'h00;
  localparam logic [5:0] OP_BNE = 6'h01;
  localparam logic [5:0] OP_ADD = 6'h02;
  localparam logic [5:0] OP_LDI = 6'h03;

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_HALT  = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] step_q,  step_d;

  // Instruction fields
  logic [5:0] op;
  logic       add_s;
  logic [1:0] add_rd, add_rs1, add_rs2;
  logic [1:0] ldi_rd;
  logic       flag_z;

  assign op      = IR_In[15:10];
  assign add_s   = IR_In[9];
  assign add_rd  = IR_In[8:7];
  assign add_rs1 = IR_In[6:5];
  assign add_rs2 = IR_In[4:3];
  assign ldi_rd  = IR_In[9:8];
  assign flag_z  = Flags[3];

  // C, N and O are carried on the bus but never steer sequencing.
  logic unused_flags;
  assign unused_flags = ^Flags[2:0];

  // R1 is the MSB of RF_RegSel, so register index n maps to bit (3-n).
  function automatic logic [3:0] rf_onehot(input logic [1:0] rd);
    return 4'b1000 >> rd;
  endfunction

  // ------------------------------------------------------------------
  // Next-state / step sequencing
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      S_FETCH: begin
        case (step_q)
          3'd0: step_d = 3'd1;
          3'd1: step_d = 3'd2;
          3'd2: begin
            if (op == HALT_OP) begin
              // Step stays at 2 while halted.
              state_d = S_HALT;
            end else if (op == OP_ADD) begin
              step_d = 3'd3;
            end else begin
              step_d = 3'd0;
            end
          end
          default: step_d = 3'd0;
        endcase
      end
      S_HALT: begin
        state_d = S_HALT;
        step_d  = step_q;
      end
      default: begin
        state_d = S_FETCH;
        step_d  = 3'd0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_FETCH;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  assign Step   = step_q;
  assign Halted = (state_q == S_HALT);

  // ------------------------------------------------------------------
  // Control decode
  // ------------------------------------------------------------------
  always_comb begin
    RF_OutASel  = '0;
    RF_OutBSel  = '0;
    RF_FunSel   = '0;
    RF_RegSel   = '0;
    RF_ScrSel   = '0;
    ALU_FunSel  = '0;
    ALU_WF      = 1'b0;
    ARF_OutCSel = '0;
    ARF_OutDSel = '0;
    ARF_FunSel  = '0;
    ARF_RegSel  = '0;
    IR_LH       = 1'b0;
    IR_Write    = 1'b0;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    DR_E        = 1'b0;
    MuxDSel     = 1'b0;
    MuxASel     = '0;
    MuxBSel     = '0;
    MuxCSel     = '0;
    DR_FunSel   = '0;
    InstrDone   = 1'b0;

    if (Reset) begin
      // Clear every architectural register while reset is held.
      ARF_RegSel = '1;
      ARF_FunSel = 2'b11;
      RF_RegSel  = '1;
      RF_FunSel  = 3'b011;
    end else if (state_q == S_FETCH) begin
      case (step_q)
        3'd0, 3'd1: begin
          // Read byte at PC into IR half selected by step, then PC++.
          ARF_OutDSel = 2'b00;
          Mem_CS      = 1'b0;
          Mem_WR      = 1'b0;
          IR_Write    = 1'b1;
          IR_LH       = step_q[0];
          ARF_RegSel  = 3'b100;
          ARF_FunSel  = 2'b01;
        end
        3'd2: begin
          InstrDone = (op != OP_ADD) || (op == HALT_OP);
          case (op)
            OP_BRA: begin
              MuxBSel    = 2'b11;
              ARF_RegSel = 3'b100;
              ARF_FunSel = 2'b10;
            end
            OP_BNE: begin
              if (!flag_z) begin
                MuxBSel    = 2'b11;
                ARF_RegSel = 3'b100;
                ARF_FunSel = 2'b10;
              end
            end
            OP_ADD: begin
              RF_OutASel = {1'b0, add_rs1};
              RF_OutBSel = {1'b0, add_rs2};
              MuxDSel    = 1'b0;
              ALU_FunSel = ADD_CODE;
            end
            OP_LDI: begin
              MuxASel   = 2'b11;
              RF_FunSel = 3'b010;
              RF_RegSel = rf_onehot(ldi_rd);
            end
            default: ;
          endcase
        end
        3'd3: begin
          // Only ADD reaches T3; the done pulse is unconditional so the
          // sequencer always returns to fetch.
          InstrDone = 1'b1;
          if (op == OP_ADD) begin
            RF_OutASel = {1'b0, add_rs1};
            RF_OutBSel = {1'b0, add_rs2};
            MuxDSel    = 1'b0;
            ALU_FunSel = ADD_CODE;
            MuxASel    = 2'b00;
            RF_FunSel  = 3'b010;
            RF_RegSel  = rf_onehot(add_rd);
            ALU_WF     = add_s;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
